// File: rtl/minisys_id_pkg.sv
// Shared types for the Minisys decode stage: branch kinds, the CU control
// bundle layout and register-address width helper.
package minisys_id_pkg;

  typedef enum logic [3:0] {
    BR_NONE,
    BR_BEQ,
    BR_BNE,
    BR_BGEZ,
    BR_BGTZ,
    BR_BLEZ,
    BR_BLTZ,
    BR_BGEZAL,
    BR_BLTZAL
  } br_type_e;

  // Last member is the LSB; the bit localparams below mirror this layout.
  typedef struct packed {
    logic [2:0] mem_size;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic [5:0] alu_op;
    logic       jal;
    logic       uses_rt;
    logic       uses_rs;
    logic       ext_zero;
    logic       shift_imm;
    br_type_e   br_type;
  } ctrl_t;

  localparam int unsigned CTRL_BITS     = $bits(ctrl_t);
  localparam int unsigned BR_TYPE_LSB   = 0;
  localparam int unsigned SHIFT_IMM_BIT = 4;
  localparam int unsigned EXT_ZERO_BIT  = 5;
  localparam int unsigned USES_RS_BIT   = 6;
  localparam int unsigned USES_RT_BIT   = 7;
  localparam int unsigned JAL_BIT       = 8;

  function automatic int unsigned reg_aw(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/minisys_regfile.sv
// Minisys register file: reg 0 hardwired to zero, two combinational read
// ports with write-first bypass, one synchronous write port, async clear.
module minisys_regfile
  import minisys_id_pkg::*;
#(
  parameter  int unsigned NREG = 32,
  parameter  int unsigned XLEN = 32,
  localparam int unsigned AW   = reg_aw(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     regs <= '{default: '0};
    else if (we && waddr != '0)  regs[waddr] <= wdata;
  end

  always_comb begin
    rdata1 = '0;
    if (raddr1 != '0) rdata1 = (we && waddr == raddr1) ? wdata : regs[raddr1];
  end

  always_comb begin
    rdata2 = '0;
    if (raddr2 != '0) rdata2 = (we && waddr == raddr2) ? wdata : regs[raddr2];
  end

endmodule

// File: rtl/minisys_id_stage.sv
// Minisys decode stage: regfile, operand/immediate select, branch resolve,
// hazard stall and ID/EX register. MINISYS_ID_FWD_EN enables EX/MEM forwarding
// into the branch comparator; without it such branches stall instead.
module minisys_id_stage
  import minisys_id_pkg::*;
#(
  parameter  int unsigned XLEN   = 32,
  parameter  int unsigned NREG   = 32,
  parameter  int unsigned CTRL_W = 24,
  localparam int unsigned REG_AW = reg_aw(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_d,
  input  logic [31:0]       instr_d,
  input  logic [XLEN-1:0]   pcplus4_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              ex_regwrite,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_wr_addr,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_wr_addr,
  input  logic [XLEN-1:0]   mem_result,
  input  logic              flush_e,
  output logic              stall_d,
  output logic              br_taken_d,
  output logic [XLEN-1:0]   br_target_d,
  output logic              valid_e,
  output logic [CTRL_W-1:0] ctrl_e,
  output logic [XLEN-1:0]   rd1_e,
  output logic [XLEN-1:0]   rd2_e,
  output logic [XLEN-1:0]   imm_e,
  output logic [REG_AW-1:0] rt_e,
  output logic [REG_AW-1:0] rd_e,
  output logic [XLEN-1:0]   pcplus4_e,
  output logic              link_e
);

  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   pcplus4;
    logic              link;
  } idex_t;

  ctrl_t             c;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [XLEN-1:0]   rf_rs, rf_rt, br_a, br_b, imm_sext, imm_d, rd1_d;
  logic              rs_use, rt_use, is_branch, load_use, br_ex_hz, br_mem_hz;
  logic              cond, link_d;
  idex_t             ex_q, ex_n;
  logic              unused_bits;

  assign c  = ctrl_t'(ctrl_d[CTRL_BITS-1:0]);
  assign rs = REG_AW'(instr_d[25:21]);
  assign rt = REG_AW'(instr_d[20:16]);
  assign rd = REG_AW'(instr_d[15:11]);

  minisys_regfile #(.NREG(NREG), .XLEN(XLEN)) u_rf (
    .clk(clk), .rst(rst), .we(wb_we), .waddr(wb_addr), .wdata(wb_data),
    .raddr1(rs), .raddr2(rt), .rdata1(rf_rs), .rdata2(rf_rt)
  );

  assign imm_sext = XLEN'($signed(instr_d[15:0]));
  assign imm_d    = c.ext_zero ? XLEN'(instr_d[15:0]) : imm_sext;
  assign rd1_d    = c.shift_imm ? XLEN'(instr_d[10:6]) : rf_rs;
  assign br_target_d = pcplus4_d + (imm_sext << 2);

  assign rs_use    = c.uses_rs && rs != '0;
  assign rt_use    = c.uses_rt && rt != '0;
  assign is_branch = c.br_type != BR_NONE;
  assign load_use  = ex_is_load && ((rs_use && ex_wr_addr == rs) || (rt_use && ex_wr_addr == rt));
  assign br_ex_hz  = is_branch && ex_regwrite &&
                     ((rs_use && ex_wr_addr == rs) || (rt_use && ex_wr_addr == rt));

`ifdef MINISYS_ID_FWD_EN
  assign br_a      = (mem_regwrite && rs != '0 && mem_wr_addr == rs) ? mem_result : rf_rs;
  assign br_b      = (mem_regwrite && rt != '0 && mem_wr_addr == rt) ? mem_result : rf_rt;
  assign br_mem_hz = 1'b0;
  assign unused_bits = ^{instr_d[31:26], instr_d[5:0], c};
`else
  // No forwarding path: hold the branch until the EX/MEM result is written back.
  assign br_a      = rf_rs;
  assign br_b      = rf_rt;
  assign br_mem_hz = is_branch && mem_regwrite &&
                     ((rs_use && mem_wr_addr == rs) || (rt_use && mem_wr_addr == rt));
  assign unused_bits = ^{instr_d[31:26], instr_d[5:0], c, mem_result};
`endif

  assign stall_d = valid_d && (load_use || br_ex_hz || br_mem_hz);

  always_comb begin
    cond = 1'b0;
    unique case (c.br_type)
      BR_BEQ:              cond = br_a == br_b;
      BR_BNE:              cond = br_a != br_b;
      BR_BGEZ, BR_BGEZAL:  cond = ~br_a[XLEN-1];
      BR_BGTZ:             cond = ~br_a[XLEN-1] && br_a != '0;
      BR_BLEZ:             cond = br_a[XLEN-1] || br_a == '0;
      BR_BLTZ, BR_BLTZAL:  cond = br_a[XLEN-1];
      default:             cond = 1'b0;
    endcase
  end

  assign br_taken_d = valid_d && cond && !stall_d;
  assign link_d     = c.jal || c.br_type == BR_BGEZAL || c.br_type == BR_BLTZAL;

  always_comb begin
    ex_n = '0;
    if (!(flush_e || stall_d))
      ex_n = '{valid: valid_d, ctrl: ctrl_d, rd1: rd1_d, rd2: rf_rt, imm: imm_d,
               rt: rt, rd: rd, pcplus4: pcplus4_d, link: link_d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_n;
  end

  assign valid_e   = ex_q.valid;
  assign ctrl_e    = ex_q.ctrl;
  assign rd1_e     = ex_q.rd1;
  assign rd2_e     = ex_q.rd2;
  assign imm_e     = ex_q.imm;
  assign rt_e      = ex_q.rt;
  assign rd_e      = ex_q.rd;
  assign pcplus4_e = ex_q.pcplus4;
  assign link_e    = ex_q.link;

endmodule
